// File: rtl/prog_mealy_fsm.sv
// prog_mealy_fsm: a table-driven Mealy state machine with registered outputs.
// Each {state, a} pair selects an entry holding the next state and the output
// symbol. The table is loaded through a small configuration port and can be
// read back one cycle later. The block also provides a synchronous clear, a
// saturating step counter and a one-cycle hit pulse when a step lands in
// match_state.
module prog_mealy_fsm #(
    parameter int SW         = 2,
    parameter int IW         = 2,
    parameter int OW         = 2,
    parameter int INIT_STATE = 0,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [IW-1:0]        a,
    output logic [OW-1:0]        y,
    output logic [SW-1:0]        state,
    input  logic [SW-1:0]        match_state,
    output logic                 hit,
    output logic [CNT_W-1:0]     step_cnt,
    input  logic                 cfg_we,
    input  logic [SW+IW-1:0]     cfg_addr,
    input  logic [SW+OW-1:0]     cfg_wdata,
    output logic [SW+OW-1:0]     cfg_rdata
);

    localparam int                AW       = SW + IW;
    localparam int                DEPTH    = 2 ** AW;
    localparam logic [SW-1:0]     INIT     = SW'(INIT_STATE);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    // One table entry: next state in the MSBs, output symbol in the LSBs.
    typedef struct packed {
        logic [SW-1:0] next_state;
        logic [OW-1:0] y_value;
    } entry_t;

    entry_t        tbl [DEPTH];
    entry_t        cur;
    logic [AW-1:0] idx;

    // The row is selected by the current state, the column by the input.
    assign idx = {state, a};
    assign cur = tbl[idx];

    // Transition table storage, written from the configuration port.
    // NOTE: the table is built from flops and must read back as all-zero after
    // reset, so every entry is cleared explicitly; a RAM macro could not do this.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            // NOTE: non-blocking assignment means any step or readback on this
            // same edge still sees the old entry (read-before-write).
            tbl[cfg_addr] <= cfg_wdata;
        end
    end

    // Registered readback of the addressed entry, pre-write contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg_rdata <= '0;
        end else begin
            cfg_rdata <= tbl[cfg_addr];
        end
    end

    // State, output, hit and step counter: clear beats enable beats hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            y        <= '0;
            hit      <= 1'b0;
            step_cnt <= '0;
        end else if (clear) begin
            state    <= INIT;
            y        <= '0;
            hit      <= 1'b0;
            step_cnt <= '0;
        end else if (enable) begin
            state <= cur.next_state;
            y     <= cur.y_value;
            hit   <= (cur.next_state == match_state);
            if (step_cnt != CNT_MAX) begin
                step_cnt <= step_cnt + CNT_W'(1);
            end
        end else begin
            hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Testbench for prog_mealy_fsm (SW=IW=OW=2). Two instances share all inputs:
// one with a 16-bit step counter and one with a 3-bit counter to exercise
// saturation. A table-level reference model predicts every output.
module tb_prog_mealy_fsm;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       clear;
    logic [1:0] a;
    logic [1:0] match_state;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [3:0] cfg_wdata;

    logic [1:0]  y;
    logic [1:0]  state;
    logic        hit;
    logic [15:0] step_cnt;
    logic [3:0]  cfg_rdata;

    logic [1:0]  s_y;
    logic [1:0]  s_state;
    logic        s_hit;
    logic [2:0]  s_step_cnt;
    logic [3:0]  s_cfg_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: table as two integer arrays, plain arithmetic indexing.
    int m_ns [16];
    int m_yv [16];
    int m_state, m_y, m_hit, m_cnt, m_cnt3, m_rdata;

    prog_mealy_fsm #(.SW(2), .IW(2), .OW(2), .INIT_STATE(0), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .a(a), .y(y), .state(state), .match_state(match_state), .hit(hit),
        .step_cnt(step_cnt), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
    );

    prog_mealy_fsm #(.SW(2), .IW(2), .OW(2), .INIT_STATE(0), .CNT_W(3)) dut_sat (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .a(a), .y(s_y), .state(s_state), .match_state(match_state), .hit(s_hit),
        .step_cnt(s_step_cnt), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(s_cfg_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_ns[i] = 0;
            m_yv[i] = 0;
        end
        m_state = 0; m_y = 0; m_hit = 0; m_cnt = 0; m_cnt3 = 0; m_rdata = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int row;
        int nxt;
        row     = m_state * 4 + int'(a);
        m_rdata = m_ns[cfg_addr] * 4 + m_yv[cfg_addr];
        if (clear) begin
            m_state = 0; m_y = 0; m_hit = 0; m_cnt = 0; m_cnt3 = 0;
        end else if (enable) begin
            nxt     = m_ns[row];
            m_y     = m_yv[row];
            m_hit   = (nxt == int'(match_state)) ? 1 : 0;
            m_state = nxt;
            m_cnt   = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
            m_cnt3  = (m_cnt3 < 7)     ? m_cnt3 + 1 : 7;
        end else begin
            m_hit = 0;
        end
        if (cfg_we) begin
            m_ns[cfg_addr] = int'(cfg_wdata) / 4;
            m_yv[cfg_addr] = int'(cfg_wdata) % 4;
        end
    endtask

    task automatic check_all();
        check("state",     32'(state),      32'(m_state));
        check("y",         32'(y),          32'(m_y));
        check("hit",       32'(hit),        32'(m_hit));
        check("step_cnt",  32'(step_cnt),   32'(m_cnt));
        check("sat_cnt",   32'(s_step_cnt), 32'(m_cnt3));
        check("cfg_rdata", 32'(cfg_rdata),  32'(m_rdata));
    endtask

    // One clock: predict, let the edge happen, sample 1 ns later, compare.
    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic wr(input int addr, input int ns, input int yv);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(addr);
        cfg_wdata = 4'(ns * 4 + yv);
        cycle();
        cfg_we    = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; a = '0;
        match_state = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        model_reset();

        // Power-on reset values.
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_rdata", 32'(cfg_rdata), 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check_all();

        // Programmed walk S0 -a0-> S1 -a1-> S2 -a1-> S3, all with y=2.
        wr(4'b00_00, 1, 2);
        wr(4'b01_01, 2, 2);
        wr(4'b10_01, 3, 2);
        match_state = 2'd3;
        enable = 1'b1;
        a = 2'd0; cycle();
        check("walk1_state", 32'(state), 1); check("walk1_y", 32'(y), 2); check("walk1_hit", 32'(hit), 0);
        a = 2'd1; cycle();
        check("walk2_state", 32'(state), 2); check("walk2_y", 32'(y), 2); check("walk2_hit", 32'(hit), 0);
        a = 2'd1; cycle();
        check("walk3_state", 32'(state), 3); check("walk3_y", 32'(y), 2); check("walk3_hit", 32'(hit), 1);
        check("walk3_cnt", 32'(step_cnt), 3);

        // Hold for five cycles.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("hold_state", 32'(state), 3); check("hold_y", 32'(y), 2);
            check("hold_cnt", 32'(step_cnt), 3); check("hold_hit", 32'(hit), 0);
        end

        // Clear wins over enable; table survives.
        clear = 1'b1; enable = 1'b1; a = 2'd1;
        cycle();
        check("clr_state", 32'(state), 0); check("clr_y", 32'(y), 0); check("clr_cnt", 32'(step_cnt), 0);
        clear = 1'b0; enable = 1'b0;
        cfg_addr = 4'b00_00; cycle(); check("clr_rd0", 32'(cfg_rdata), 4'b01_10);
        cfg_addr = 4'b01_01; cycle(); check("clr_rd5", 32'(cfg_rdata), 4'b10_10);
        cfg_addr = 4'b10_01; cycle(); check("clr_rd9", 32'(cfg_rdata), 4'b11_10);

        // Write/step collision on {S0,a=0}: step uses the old entry.
        enable = 1'b1; a = 2'd0;
        cfg_we = 1'b1; cfg_addr = 4'b00_00; cfg_wdata = 4'b11_01;
        cycle();
        check("coll_state", 32'(state), 1); check("coll_y", 32'(y), 2);
        check("coll_rd_old", 32'(cfg_rdata), 4'b01_10);
        cfg_we = 1'b0; enable = 1'b0;
        cycle();
        check("coll_rd_new", 32'(cfg_rdata), 4'b11_01);
        clear = 1'b1; cycle(); clear = 1'b0;
        enable = 1'b1; a = 2'd0;
        cycle();
        check("coll2_state", 32'(state), 3); check("coll2_y", 32'(y), 1); check("coll2_hit", 32'(hit), 1);

        // Saturation of the 3-bit counter instance.
        clear = 1'b1; enable = 1'b0; cycle(); clear = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            a = 2'($urandom);
            cycle();
            check("sat_step", 32'(s_step_cnt), (i < 7) ? i : 7);
        end
        enable = 1'b0; clear = 1'b1;
        cycle();
        check("sat_clr", 32'(s_step_cnt), 0);
        clear = 1'b0;

        // Reset asserted mid-stepping clears everything without a clock edge.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 2'($urandom);
            cycle();
        end
        #3 reset_n = 1'b0;
        #1;
        check("mrst_state", 32'(state), 0); check("mrst_y", 32'(y), 0);
        check("mrst_hit", 32'(hit), 0); check("mrst_cnt", 32'(step_cnt), 0);
        check("mrst_rdata", 32'(cfg_rdata), 0);
        model_reset();
        @(posedge clock); #1;
        check_all();
        reset_n = 1'b1; enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cfg_addr = 4'(i);
            cycle();
            check("mrst_tbl", 32'(cfg_rdata), 0);
        end

        // Random table, then random traffic against the model.
        for (int i = 0; i < 16; i++) begin
            wr(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 10000; i++) begin
            a           = 2'($urandom);
            enable      = ($urandom_range(0, 3) != 0);
            clear       = ($urandom_range(0, 19) == 0);
            match_state = 2'($urandom);
            cfg_we      = ($urandom_range(0, 31) == 0);
            cfg_addr    = 4'($urandom);
            cfg_wdata   = 4'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
